// File: rtl/scan_chain_ctrl.sv
// Scan-chain sequencer: shift a pattern in, run one capture cycle, shift the response out.
// Optional response comparator: define SCAN_CHAIN_CTRL_CMP_EN.
module scan_chain_ctrl #(
  parameter int CHAIN_LEN = 8,
  parameter int CNT_W     = 4
) (
  input  logic                 clk,
  input  logic                 reset_L,
  input  logic                 start,
  input  logic [CHAIN_LEN-1:0] pattern,
  input  logic [CHAIN_LEN-1:0] expected,
  input  logic                 scan_out,
  output logic                 SE,
  output logic                 SD,
  output logic                 busy,
  output logic                 done,
  output logic [CHAIN_LEN-1:0] response,
  output logic                 pass
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    SHIFT_IN  = 3'd1,
    CAPTURE   = 3'd2,
    SHIFT_OUT = 3'd3,
    DONE      = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0]     CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]     CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(CHAIN_LEN - 1);
  localparam logic [CHAIN_LEN-1:0] VEC_ZERO = {CHAIN_LEN{1'b0}};

  state_t               state_r, state_nx_s;
  logic [CNT_W-1:0]     cnt_r, cnt_nx_s;
  logic [CHAIN_LEN-1:0] pat_r, pat_nx_s;
  logic [CHAIN_LEN-1:0] resp_r, resp_nx_s, resp_fin_s, pat_sh_s;
  logic                 last_s;
  logic                 se_nx_s, sd_nx_s, busy_nx_s, done_nx_s;
  logic                 se_r, sd_r, busy_r, done_r;

  // Next-state, bit counter, pattern latch and response assembly
  always_comb begin
    state_nx_s = state_r;
    cnt_nx_s   = cnt_r;
    pat_nx_s   = pat_r;
    resp_nx_s  = resp_r;
    last_s     = (cnt_r == CNT_LAST);
    // Response with the bit currently on the chain tail merged in at position cnt
    resp_fin_s = resp_r | ({{(CHAIN_LEN-1){1'b0}}, scan_out} << cnt_r);
    case (state_r)
      IDLE: begin
        if (start) begin
          state_nx_s = SHIFT_IN;
          cnt_nx_s   = CNT_ZERO;
          pat_nx_s   = pattern;
          resp_nx_s  = VEC_ZERO;
        end else begin
          state_nx_s = IDLE;
        end
      end
      SHIFT_IN: begin
        if (last_s) begin
          state_nx_s = CAPTURE;
          cnt_nx_s   = CNT_ZERO;
        end else begin
          cnt_nx_s   = cnt_r + CNT_ONE;
        end
      end
      CAPTURE: begin
        state_nx_s = SHIFT_OUT;
        cnt_nx_s   = CNT_ZERO;
      end
      SHIFT_OUT: begin
        resp_nx_s = resp_fin_s;
        if (last_s) begin
          state_nx_s = DONE;
          cnt_nx_s   = CNT_ZERO;
        end else begin
          cnt_nx_s   = cnt_r + CNT_ONE;
        end
      end
      DONE: begin
        state_nx_s = IDLE;
        cnt_nx_s   = CNT_ZERO;
      end
      default: begin
        state_nx_s = IDLE;
        cnt_nx_s   = CNT_ZERO;
      end
    endcase
    // Outputs are decoded one cycle early and registered, so they follow state with no input path
    pat_sh_s  = pat_nx_s >> cnt_nx_s;
    se_nx_s   = (state_nx_s == SHIFT_IN) || (state_nx_s == SHIFT_OUT);
    sd_nx_s   = (state_nx_s == SHIFT_IN) ? pat_sh_s[0] : 1'b0;
    busy_nx_s = (state_nx_s == SHIFT_IN) || (state_nx_s == CAPTURE) ||
                (state_nx_s == SHIFT_OUT);
    done_nx_s = (state_nx_s == DONE);
  end

  // State, counter, latched pattern and response registers
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      state_r <= IDLE;
      cnt_r   <= CNT_ZERO;
      pat_r   <= VEC_ZERO;
      resp_r  <= VEC_ZERO;
    end else begin
      state_r <= state_nx_s;
      cnt_r   <= cnt_nx_s;
      pat_r   <= pat_nx_s;
      resp_r  <= resp_nx_s;
    end
  end

  // Registered scan-control and handshake outputs
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      se_r   <= 1'b0;
      sd_r   <= 1'b0;
      busy_r <= 1'b0;
      done_r <= 1'b0;
    end else begin
      se_r   <= se_nx_s;
      sd_r   <= sd_nx_s;
      busy_r <= busy_nx_s;
      done_r <= done_nx_s;
    end
  end

  assign SE       = se_r;
  assign SD       = sd_r;
  assign busy     = busy_r;
  assign done     = done_r;
  assign response = resp_r;

`ifdef SCAN_CHAIN_CTRL_CMP_EN
  logic [CHAIN_LEN-1:0] exp_r;
  logic                 pass_r;

  function automatic logic vec_match(input logic [CHAIN_LEN-1:0] a,
                                     input logic [CHAIN_LEN-1:0] b);
    return (a == b);
  endfunction

  // Expected-vector latch and compare result, evaluated on the final unload edge
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      exp_r  <= VEC_ZERO;
      pass_r <= 1'b0;
    end else if ((state_r == IDLE) && start) begin
      exp_r  <= expected;
      pass_r <= 1'b0;
    end else if ((state_r == SHIFT_OUT) && last_s) begin
      pass_r <= vec_match(resp_fin_s, exp_r);
    end
  end

  assign pass = pass_r;
`else
  logic unused_expected_s;
  assign unused_expected_s = ^expected;
  assign pass = 1'b0;
`endif

endmodule

// File: tb/tb_scan_chain_ctrl.sv
// Randomized self-checking bench for scan_chain_ctrl with a behavioural scan-chain model.
module tb_scan_chain_ctrl;
  localparam int N  = 8;
  localparam int CW = 4;
`ifdef SCAN_CHAIN_CTRL_CMP_EN
  localparam bit CMP = 1'b1;
`else
  localparam bit CMP = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset_L = 1'b1;
  logic         start = 1'b0;
  logic [N-1:0] pattern = '0;
  logic [N-1:0] expected = '0;
  logic         scan_out;
  logic         SE, SD, busy, done, pass;
  logic [N-1:0] response;

  int n_checks = 0;
  int n_fail   = 0;

  // Chain model: chain[0] is the first cell, chain[N-1] drives scan_out
  bit           chain_transparent = 1'b1;
  logic [N-1:0] chain_tie = '0;
  logic [N-1:0] chain = '0;

  always #5 clk = ~clk;

  scan_chain_ctrl #(.CHAIN_LEN(N), .CNT_W(CW)) dut (
    .clk(clk), .reset_L(reset_L), .start(start), .pattern(pattern),
    .expected(expected), .scan_out(scan_out), .SE(SE), .SD(SD),
    .busy(busy), .done(done), .response(response), .pass(pass)
  );

  assign scan_out = chain[N-1];

  // Tied capture: cell j loads tie[N-1-j], so an unload presents tie in bit order
  always @(posedge clk) begin
    if (SE) chain <= {chain[N-2:0], SD};
    else if (!chain_transparent) for (int j = 0; j < N; j++) chain[j] <= chain_tie[N-1-j];
  end

  // One complete test from an IDLE cycle; returns positioned in the IDLE cycle after DONE
  task automatic run_test(input logic [N-1:0] pat, input logic [N-1:0] exp,
                          input bit hold, input bit toggle, input string tag);
    logic [N-1:0] ref_resp, ref_cells;
    logic         ref_pass, e_se, e_sd, e_busy, e_done, e_pass;
    ref_resp = chain_transparent ? pat : chain_tie;
    ref_pass = CMP && (ref_resp == exp);
    for (int i = 0; i < N; i++) ref_cells[i] = pat[N-1-i];

    n_checks++;
    if ({SE, SD, busy, done} !== 4'b0000) begin
      n_fail++;
      $display("FAIL %s idle_pre: SE,SD,busy,done=%b required 0000", tag, {SE, SD, busy, done});
    end
    pattern = pat; expected = exp; start = 1'b1;
    @(posedge clk); #1;
    for (int c = 1; c <= 2*N+2; c++) begin
      e_se   = (c <= N) || (c >= N+2 && c <= 2*N+1);
      e_sd   = (c <= N) ? pat[c-1] : 1'b0;
      e_busy = (c <= 2*N+1);
      e_done = (c == 2*N+2);
      e_pass = (c == 2*N+2) ? ref_pass : 1'b0;
      n_checks++;
      if ({SE, SD, busy, done} !== {e_se, e_sd, e_busy, e_done}) begin
        n_fail++;
        $display("FAIL %s ctrl cycle %0d: SE,SD,busy,done=%b required %b",
                 tag, c, {SE, SD, busy, done}, {e_se, e_sd, e_busy, e_done});
      end
      n_checks++;
      if (pass !== e_pass) begin
        n_fail++;
        $display("FAIL %s pass cycle %0d: got %b required %b", tag, c, pass, e_pass);
      end
      if (c == 1) begin
        n_checks++;
        if (response !== '0) begin
          n_fail++;
          $display("FAIL %s resp_clear: got %h required 00", tag, response);
        end
      end
      if (c == N+1) begin
        n_checks++;
        if (chain !== ref_cells) begin
          n_fail++;
          $display("FAIL %s shift_in_cells: got %b required %b", tag, chain, ref_cells);
        end
      end
      if (c == 2*N+2) begin
        n_checks++;
        if (response !== ref_resp) begin
          n_fail++;
          $display("FAIL %s response: got %h required %h", tag, response, ref_resp);
        end
      end
      if (c < 2*N+2) begin
        start    = toggle ? 1'($urandom_range(0, 1)) : hold;
        pattern  = N'($urandom);
        expected = N'($urandom);
      end else begin
        start = hold;
      end
      @(posedge clk); #1;
    end
    n_checks++;
    if ({busy, done, pass, response} !== {1'b0, 1'b0, ref_pass, ref_resp}) begin
      n_fail++;
      $display("FAIL %s idle_post: busy,done,pass,resp=%b,%b,%b,%h required 0,0,%b,%h",
               tag, busy, done, pass, response, ref_pass, ref_resp);
    end
  endtask

  task automatic test_reset();
    #1 reset_L = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if ({SE, SD, busy, done, pass, response} !== {5'b00000, {N{1'b0}}}) begin
      n_fail++;
      $display("FAIL reset_state: SE,SD,busy,done,pass=%b resp=%h required 00000 00",
               {SE, SD, busy, done, pass}, response);
    end
    @(negedge clk) reset_L = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_transparent();
    chain_transparent = 1'b1;
    run_test(8'hA5, 8'hA5, 1'b0, 1'b0, "transparent_a5");
  endtask

  task automatic test_tied_capture();
    chain_transparent = 1'b0;
    chain_tie = 8'h3C;
    run_test(8'hFF, 8'h3C, 1'b0, 1'b0, "tied_3c_match");
    run_test(8'hFF, 8'h3D, 1'b0, 1'b0, "tied_3c_miss");
    chain_transparent = 1'b1;
  endtask

  task automatic test_shift_order();
    chain_transparent = 1'b1;
    run_test(8'h01, 8'h01, 1'b0, 1'b0, "shift_order_01");
  endtask

  task automatic test_random();
    logic [N-1:0] p, e;
    for (int k = 0; k < 8; k++) begin
      chain_transparent = 1'($urandom_range(0, 1));
      chain_tie = N'($urandom);
      p = N'($urandom);
      e = $urandom_range(0, 1) ? (chain_transparent ? p : chain_tie) : N'($urandom);
      run_test(p, e, 1'b0, 1'b1, "random");
    end
    chain_transparent = 1'b1;
  endtask

  task automatic test_back_to_back();
    chain_transparent = 1'b1;
    run_test(8'h5A, 8'h5A, 1'b1, 1'b0, "b2b_0");
    run_test(8'hC3, 8'h00, 1'b1, 1'b0, "b2b_1");
    run_test(8'h96, 8'h96, 1'b0, 1'b0, "b2b_2");
  endtask

  task automatic test_reset_mid_shift();
    chain_transparent = 1'b1;
    pattern = 8'hA5; expected = 8'hA5; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (N+4) @(posedge clk);
    #1;
    n_checks++;
    if ({SE, busy} !== 2'b11) begin
      n_fail++;
      $display("FAIL midrst_pre: SE,busy=%b required 11", {SE, busy});
    end
    #3 reset_L = 1'b0;
    #1;
    n_checks++;
    if ({SE, SD, busy, done, pass, response} !== {5'b00000, {N{1'b0}}}) begin
      n_fail++;
      $display("FAIL midrst_async: SE,SD,busy,done,pass=%b resp=%h required 00000 00",
               {SE, SD, busy, done, pass}, response);
    end
    repeat (2) @(posedge clk);
    @(negedge clk) reset_L = 1'b1;
    for (int c = 0; c < 2*N+4; c++) begin
      @(posedge clk); #1;
      n_checks++;
      if ({busy, done} !== 2'b00) begin
        n_fail++;
        $display("FAIL midrst_no_done cycle %0d: busy,done=%b required 00", c, {busy, done});
      end
    end
    run_test(8'hA5, 8'hA5, 1'b0, 1'b0, "after_reset");
  endtask

  initial begin
    test_reset();
    test_transparent();
    test_tied_capture();
    test_shift_order();
    test_random();
    test_back_to_back();
    test_reset_mid_shift();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
